// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: control-bit indices, size encodings,
// FSM state type and the EX/MEM bubble.
package mem_stage_pkg;

    localparam int unsigned MemReadBit  = 0;
    localparam int unsigned MemWriteBit = 1;
    localparam int unsigned MemSizeLsb  = 2;

    localparam logic [1:0] SizeWord  = 2'b00;
    localparam logic [1:0] SizeHalf  = 2'b01;
    localparam logic [1:0] SizeByte  = 2'b10;
    localparam logic [1:0] SizeWord2 = 2'b11;

    typedef enum logic [0:0] {
        StIdle,
        StAccess
    } mem_state_e;

    typedef struct packed {
        logic [31:0] result;
        logic [31:0] store_data;
        logic [4:0]  wreg;
        logic [3:0]  mem_ctrl;
        logic [1:0]  wb_ctrl;
    } exmem_t;

    localparam exmem_t ExmemBubble = '0;

    function automatic logic is_misaligned(logic [1:0] size, logic [1:0] addr_lo);
        logic mis;
        unique case (size)
            SizeHalf: mis = addr_lo[0];
            SizeByte: mis = 1'b0;
            default:  mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane steering: byte enables, replicated store data, load extraction with
// sign extension, and misalignment detection.
module mem_align
    import mem_stage_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic        misalign,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    assign misalign = is_misaligned(size, addr_lo);
    assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        byte_sel = rdata[7:0];
        unique case (addr_lo)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
        endcase
    end

    always_comb begin
        be        = 4'b1111;
        wdata     = store_data;
        load_data = rdata;
        unique case (size)
            SizeHalf: begin
                be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata     = {2{store_data[15:0]}};
                load_data = {{16{half_sel[15]}}, half_sel};
            end
            SizeByte: begin
                be        = 4'b0001 << addr_lo;
                wdata     = {4{store_data[7:0]}};
                load_data = {{24{byte_sel[7]}}, byte_sel};
            end
            default: begin
                be        = 4'b1111;
                wdata     = store_data;
                load_data = rdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM and MEM/WB registers plus a two-state data-memory handshake.
// Optional access timeout enabled by defining MEM_TIMEOUT_EN.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [31:0] Result,
    input  logic [31:0] OutB,
    input  logic [4:0]  WriteReg,
    input  logic [3:0]  MEMReg,
    input  logic [1:0]  WBReg,
    output logic        stall,
    output logic [31:0] ALUop_inMEM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [1:0]  WBRegOut,
    output logic [31:0] ReadData,
    output logic [31:0] ALUResult,
    output logic [4:0]  WriteRegOut,
    output logic        misalign,
    output logic        mem_err
);

    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be nonzero");
    end

    exmem_t     exmem_q, exmem_d;
    mem_state_e state_q, state_d;

    logic        exmem_is_mem;
    logic        exmem_is_read;
    logic        align_mis;
    logic [3:0]  align_be;
    logic [31:0] load_data;
    logic        incoming_access;
    logic        timeout;
    logic        done;

    mem_align u_align (
        .size       (exmem_q.mem_ctrl[MemSizeLsb +: 2]),
        .addr_lo    (exmem_q.result[1:0]),
        .store_data (exmem_q.store_data),
        .rdata      (dmem_rdata),
        .misalign   (align_mis),
        .be         (align_be),
        .wdata      (dmem_wdata),
        .load_data  (load_data)
    );

    assign exmem_is_mem  = exmem_q.mem_ctrl[MemReadBit] | exmem_q.mem_ctrl[MemWriteBit];
    // Write wins when both MemRead and MemWrite are set.
    assign exmem_is_read = exmem_q.mem_ctrl[MemReadBit] & ~exmem_q.mem_ctrl[MemWriteBit];

    assign incoming_access = !flush && (MEMReg[MemReadBit] || MEMReg[MemWriteBit])
                             && !is_misaligned(MEMReg[MemSizeLsb +: 2], Result[1:0]);

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CntW-1:0] cnt_q;
    logic            mem_err_q;

    assign timeout = (state_q == StAccess) && !dmem_ack
                     && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            mem_err_q <= 1'b0;
        end else begin
            if (state_q == StAccess && !done) begin
                cnt_q <= cnt_q + 1'b1;
            end else begin
                cnt_q <= '0;
            end
            if (timeout) begin
                mem_err_q <= 1'b1;
            end
        end
    end

    assign mem_err = mem_err_q;
`else
    assign timeout = 1'b0;
    assign mem_err = 1'b0;
`endif

    assign done  = (state_q == StAccess) && (dmem_ack || timeout);
    assign stall = (state_q == StAccess) && !done;

    assign dmem_req    = (state_q == StAccess);
    assign dmem_we     = dmem_req && exmem_q.mem_ctrl[MemWriteBit];
    assign dmem_addr   = {exmem_q.result[31:2], 2'b00};
    assign dmem_be     = dmem_req ? align_be : 4'b0000;
    assign misalign    = exmem_is_mem && align_mis;
    assign ALUop_inMEM = exmem_q.result;

    always_comb begin
        exmem_d = exmem_q;
        state_d = state_q;
        if (!stall) begin
            exmem_d = flush ? ExmemBubble
                            : '{result: Result, store_data: OutB, wreg: WriteReg,
                                mem_ctrl: MEMReg, wb_ctrl: WBReg};
            state_d = incoming_access ? StAccess : StIdle;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exmem_q <= ExmemBubble;
            state_q <= StIdle;
        end else begin
            exmem_q <= exmem_d;
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            WBRegOut    <= 2'b00;
            ReadData    <= 32'h0;
            ALUResult   <= 32'h0;
            WriteRegOut <= 5'd0;
        end else if (!stall) begin
            // Failed accesses retire with write-back disabled.
            WBRegOut    <= (misalign || timeout) ? 2'b00 : exmem_q.wb_ctrl;
            ALUResult   <= exmem_q.result;
            WriteRegOut <= exmem_q.wreg;
            ReadData    <= (state_q == StAccess && dmem_ack && exmem_is_read) ? load_data : 32'h0;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [31:0] Result;
    logic [31:0] OutB;
    logic [4:0]  WriteReg;
    logic [3:0]  MEMReg;
    logic [1:0]  WBReg;
    logic        stall;
    logic [31:0] ALUop_inMEM;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic [1:0]  WBRegOut;
    logic [31:0] ReadData;
    logic [31:0] ALUResult;
    logic [4:0]  WriteRegOut;
    logic        misalign;
    logic        mem_err;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .Result      (Result),
        .OutB        (OutB),
        .WriteReg    (WriteReg),
        .MEMReg      (MEMReg),
        .WBReg       (WBReg),
        .stall       (stall),
        .ALUop_inMEM (ALUop_inMEM),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_be     (dmem_be),
        .dmem_wdata  (dmem_wdata),
        .dmem_ack    (dmem_ack),
        .dmem_rdata  (dmem_rdata),
        .WBRegOut    (WBRegOut),
        .ReadData    (ReadData),
        .ALUResult   (ALUResult),
        .WriteRegOut (WriteRegOut),
        .misalign    (misalign),
        .mem_err     (mem_err)
    );

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] res, input logic [31:0] outb, input logic [4:0] wreg,
                         input logic [3:0] mem, input logic [1:0] wb);
        Result   = res;
        OutB     = outb;
        WriteReg = wreg;
        MEMReg   = mem;
        WBReg    = wb;
    endtask

    initial begin
        rst        = 1'b1;
        flush      = 1'b0;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        drive(32'h0, 32'h0, 5'd0, 4'b0000, 2'b00);
        step();
        step();
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_be", 32'(dmem_be), 32'd0);
        chk("rst_wb", 32'(WBRegOut), 32'd0);
        chk("rst_rdata", ReadData, 32'h0);
        chk("rst_err", 32'(mem_err), 32'd0);

        // Word load at 0x100, ack after two wait cycles.
        rst = 1'b0;
        drive(32'h100, 32'h0, 5'd5, 4'b0001, 2'b11);
        step();
        chk("wl_req", 32'(dmem_req), 32'd1);
        chk("wl_stall1", 32'(stall), 32'd1);
        chk("wl_addr", dmem_addr, 32'h100);
        chk("wl_be", 32'(dmem_be), 32'hF);
        chk("wl_we", 32'(dmem_we), 32'd0);
        drive(32'h55, 32'h0, 5'd7, 4'b0000, 2'b01);
        step();
        chk("wl_stall2", 32'(stall), 32'd1);
        step();
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hDEADBEEF;
        #1;
        chk("wl_stall_ack", 32'(stall), 32'd0);
        chk("wl_req_ack", 32'(dmem_req), 32'd1);
        step();
        dmem_ack = 1'b0;
        chk("wl_rdata", ReadData, 32'hDEADBEEF);
        chk("wl_wbout", 32'(WBRegOut), 32'd3);
        chk("wl_wreg", 32'(WriteRegOut), 32'd5);
        chk("wl_alures", ALUResult, 32'h100);
        chk("wl_req_done", 32'(dmem_req), 32'd0);
        chk("alu_fwd", ALUop_inMEM, 32'h55);
        step();
        chk("alu_alures", ALUResult, 32'h55);
        chk("alu_rdata", ReadData, 32'h0);
        chk("alu_wbout", 32'(WBRegOut), 32'd1);
        chk("alu_wreg", 32'(WriteRegOut), 32'd7);

        // Byte load at 0x103, zero-wait ack.
        drive(32'h103, 32'h0, 5'd3, 4'b1001, 2'b11);
        step();
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h80FFFFFF;
        #1;
        chk("lb_be", 32'(dmem_be), 32'h8);
        chk("lb_stall", 32'(stall), 32'd0);
        drive(32'h0, 32'h0, 5'd0, 4'b0000, 2'b00);
        step();
        dmem_ack = 1'b0;
        chk("lb_rdata", ReadData, 32'hFFFFFF80);
        chk("lb_wreg", 32'(WriteRegOut), 32'd3);
        chk("lb_req_done", 32'(dmem_req), 32'd0);

        // Half store at 0x102.
        drive(32'h102, 32'h1234ABCD, 5'd0, 4'b0110, 2'b10);
        step();
        chk("sh_be", 32'(dmem_be), 32'hC);
        chk("sh_wdata", dmem_wdata, 32'hABCDABCD);
        chk("sh_we", 32'(dmem_we), 32'd1);
        chk("sh_addr", dmem_addr, 32'h100);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h12345678;
        drive(32'h0, 32'h0, 5'd0, 4'b0000, 2'b00);
        step();
        dmem_ack = 1'b0;
        chk("sh_rdata", ReadData, 32'h0);
        chk("sh_wbout", 32'(WBRegOut), 32'd2);

        // Read and write both set: treated as a write.
        drive(32'h10, 32'h000000A5, 5'd2, 4'b1011, 2'b01);
        step();
        chk("rw_we", 32'(dmem_we), 32'd1);
        chk("rw_be", 32'(dmem_be), 32'h1);
        chk("rw_wdata", dmem_wdata, 32'hA5A5A5A5);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h12345678;
        drive(32'h0, 32'h0, 5'd0, 4'b0000, 2'b00);
        step();
        dmem_ack = 1'b0;
        chk("rw_rdata", ReadData, 32'h0);

        // Misaligned word load.
        drive(32'h101, 32'h0, 5'd9, 4'b0001, 2'b11);
        step();
        chk("mis_pulse", 32'(misalign), 32'd1);
        chk("mis_req", 32'(dmem_req), 32'd0);
        chk("mis_stall", 32'(stall), 32'd0);
        drive(32'h0, 32'h0, 5'd0, 4'b0000, 2'b00);
        step();
        chk("mis_pulse_end", 32'(misalign), 32'd0);
        chk("mis_wbout", 32'(WBRegOut), 32'd0);
        chk("mis_wreg", 32'(WriteRegOut), 32'd9);
        chk("mis_req2", 32'(dmem_req), 32'd0);

        // Half load at 0x102 sign-extends the upper half.
        drive(32'h102, 32'h0, 5'd4, 4'b0101, 2'b11);
        step();
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h80017FFF;
        drive(32'h0, 32'h0, 5'd0, 4'b0000, 2'b00);
        step();
        dmem_ack = 1'b0;
        chk("lh_rdata", ReadData, 32'hFFFF8001);

        // Positive byte at 0x001.
        drive(32'h1, 32'h0, 5'd4, 4'b1001, 2'b11);
        step();
        chk("lb1_be", 32'(dmem_be), 32'h2);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h00007F00;
        drive(32'h0, 32'h0, 5'd0, 4'b0000, 2'b00);
        step();
        dmem_ack = 1'b0;
        chk("lb1_rdata", ReadData, 32'h0000007F);

        // Flush loads a bubble; ignored while stalled.
        flush = 1'b1;
        drive(32'h300, 32'h0, 5'd6, 4'b0001, 2'b11);
        step();
        chk("fl_req", 32'(dmem_req), 32'd0);
        chk("fl_bubble", ALUop_inMEM, 32'h0);
        flush = 1'b0;
        step();
        chk("fl_load_req", 32'(dmem_req), 32'd1);
        flush = 1'b1;
        drive(32'h77, 32'h0, 5'd1, 4'b0000, 2'b01);
        step();
        chk("fl_stall_hold", ALUop_inMEM, 32'h300);
        chk("fl_stall", 32'(stall), 32'd1);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h0;
        step();
        dmem_ack = 1'b0;
        flush    = 1'b0;
        chk("fl_after_ack", ALUop_inMEM, 32'h0);
        chk("fl_alures", ALUResult, 32'h300);
        chk("fl_req_done", 32'(dmem_req), 32'd0);
        drive(32'h0, 32'h0, 5'd0, 4'b0000, 2'b00);

        // Access with no ack.
        drive(32'h200, 32'h0, 5'd8, 4'b0001, 2'b11);
        step();
        drive(32'h0, 32'h0, 5'd0, 4'b0000, 2'b00);
`ifdef MEM_TIMEOUT_EN
        chk("to_stall0", 32'(stall), 32'd1);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("to_stall", 32'(stall), 32'd1);
        end
        step();
        chk("to_last_stall", 32'(stall), 32'd0);
        chk("to_last_req", 32'(dmem_req), 32'd1);
        chk("to_err_pre", 32'(mem_err), 32'd0);
        step();
        chk("to_req", 32'(dmem_req), 32'd0);
        chk("to_err", 32'(mem_err), 32'd1);
        chk("to_wbout", 32'(WBRegOut), 32'd0);
        chk("to_rdata", ReadData, 32'h0);
        chk("to_alures", ALUResult, 32'h200);
        step();
        step();
        chk("to_err_sticky", 32'(mem_err), 32'd1);
`else
        chk("nt_stall0", 32'(stall), 32'd1);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("nt_stall", 32'(stall), 32'd1);
        end
        chk("nt_err", 32'(mem_err), 32'd0);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hCAFEF00D;
        step();
        dmem_ack = 1'b0;
        chk("nt_rdata", ReadData, 32'hCAFEF00D);
        chk("nt_wbout", 32'(WBRegOut), 32'd3);
`endif

        // Asynchronous reset in the middle of an access.
        drive(32'h400, 32'h0, 5'd10, 4'b0001, 2'b11);
        step();
        chk("ar_req_pre", 32'(dmem_req), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("ar_req", 32'(dmem_req), 32'd0);
        chk("ar_stall", 32'(stall), 32'd0);
        chk("ar_alu", ALUop_inMEM, 32'h0);
        chk("ar_addr", dmem_addr, 32'h0);
        chk("ar_be", 32'(dmem_be), 32'h0);
        chk("ar_wbout", 32'(WBRegOut), 32'd0);
        chk("ar_alures", ALUResult, 32'h0);
        chk("ar_wreg", 32'(WriteRegOut), 32'd0);
        chk("ar_err", 32'(mem_err), 32'd0);
        #3;
        rst = 1'b0;
        drive(32'h0, 32'h0, 5'd0, 4'b0000, 2'b00);
        step();
        chk("ar_idle", 32'(dmem_req), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
